uart_hex_tx: RTL and testbench
==============================

# uart_hex_tx

Formatter that sits directly upstream of the 8-bit UART transmitter. It accepts a binary word, such as an iteration count or a pixel result, and drives the transmitter's data/start/busy handshake. The word is sent as uppercase ASCII hex, most significant nibble first, optionally followed by CR LF. This lets result values be dumped to a host terminal without a CPU.

## Interface
Parameters:
- NIBBLES, default 8: number of hex digits sent per word. Legal range is 1..8. Input width is 4*NIBBLES.
- CRLF, default 1: when 1, append 0x0D then 0x0A after the digits. When 0, send digits only.

Ports:
- clk  in  1  system clock (24 MHz).
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- din  in  4*NIBBLES  word to send. Sampled only on accept.
- valid  in  1  request. Accepted when valid=1 and ready=1 on a rising clk edge.
- ready  out  1  high only in IDLE.
- tx_data  out  8  byte presented to the transmitter.
- tx_start  out  1  single-cycle start strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- done  out  1  one-cycle pulse after the last byte's frame completes.

## Operation
- States: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE
  - ready=1.
  - On accept: latch din into a shift register, set char index = 0, go to LOAD.
  - valid with ready=0 is ignored. There is no queueing.
- LOAD
  - tx_data = char(index).
  - If tx_busy=0: tx_start=1 for this cycle, go to WAIT_HI.
  - If tx_busy=1 (the transmitter is still finishing a foreign frame): stay in LOAD with tx_start=0.
- WAIT_HI
  - Hold tx_data. tx_start=0.
  - Wait for tx_busy=1, then go to WAIT_LO. There is no timeout.
- WAIT_LO
  - Wait for tx_busy=0.
  - If index = last: done=1 for one cycle, go to IDLE.
  - Otherwise: index+1, go to LOAD.
- Character mapping
  - Digit k (k=0 is the MSB nibble) is n = din[4*(NIBBLES-k)-1 -: 4].
  - n<10 gives 0x30+n. n>=10 gives 0x37+n ('A'..'F', uppercase only).
  - Digits are taken by left-shifting the latched word 4 bits per character.
  - Indices NIBBLES and NIBBLES+1 give 0x0D and 0x0A when CRLF=1.
  - last = NIBBLES-1+2*CRLF.
- Index counter is 4 bits and never wraps within a word; maximum index is 9.
- Reset
  - Applies immediately (asynchronous) in any state: state=IDLE, tx_start=0, tx_data=0x00, done=0, index=0, latched word=0.
  - ready=1 from reset release.
  - A frame already started in the transmitter completes on its own. The formatter does not wait for it, and the LOAD check handles it.

## Timing
- Reset values: ready=1, tx_start=0, tx_data=0x00, done=0.
- Accept at edge E: ready=0 from E, LOAD during cycle after E, tx_start high in that cycle (given tx_busy=0).
- tx_data becomes valid in the same cycle as tx_start and stays stable until the next LOAD, or until reset.
- The transmitter raises busy the cycle after start. WAIT_HI therefore normally lasts 1 cycle.
- Per byte, beyond the transmitter's busy time: 1 LOAD cycle + 1 WAIT_HI cycle + 1 cycle to observe busy low.
- done and the IDLE transition coincide with the first cycle tx_busy is seen low after the last byte. ready=1 the following cycle.
- Back-to-back words: valid held high is accepted on the first IDLE cycle. Minimum gap between done and the next tx_start is 2 cycles.
- tx_start is never high in two consecutive cycles and never high while tx_busy=1.

## Test plan
- NIBBLES=8, CRLF=1, transmitter model at 208 clk/bit, din=0x1234ABCF.
  - Bytes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x46 0x0D 0x0A, in order.
  - Exactly 10 tx_start pulses, one done pulse after the 10th frame.
  - Serial line decode matches.
- NIBBLES=2, CRLF=0, din=0x0F, then 0xA9 with valid held high.
  - Bytes 0x30 0x46, done, then 0x41 0x39, done.
  - The second word is accepted in the first cycle ready=1.
- Pulse valid with din=0x5 while ready=0 mid-word: ignored. The byte stream of the in-flight word is unchanged.
- Hold tx_busy=1 externally for 50 cycles when a word is accepted: no tx_start for those 50 cycles, then start in the first cycle busy=0.
- Assert rst low during byte 3 of 0xDEADBEEF: outputs reach reset values immediately and ready=1 after release. A new word 0x00000001 then sends 0x30 ×7, 0x31, 0x0D, 0x0A.
- Check all 16 nibble values: din=0x0123456789ABCDEF with NIBBLES split over two 8-digit words gives '0'..'9','A'..'F'.

Source files
------------

// File: rtl/uart_hex_tx.sv
// uart_hex_tx
// Formats a binary word as uppercase ASCII hex (MSB nibble first), optionally
// followed by CR LF, and feeds it byte by byte to an 8-bit UART transmitter
// through its data/start/busy handshake.
//
// Parameters
//   NIBBLES  hex digits per word (1..8); din is 4*NIBBLES bits wide
//   CRLF     1: append 0x0D 0x0A after the digits, 0: digits only
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-low reset
//   din       word to send, sampled only when a request is accepted
//   valid     request; accepted on a rising clk edge while ready=1
//   ready     high only while idle
//   tx_data   byte presented to the transmitter
//   tx_start  single-cycle start strobe to the transmitter
//   tx_busy   transmitter busy flag
//   done      one-cycle pulse when the last byte's frame has completed
module uart_hex_tx #(
  parameter int NIBBLES = 8,
  parameter int CRLF    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] din,
  input  logic                 valid,
  output logic                 ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 done
);

  localparam int         W        = 4 * NIBBLES;
  // Index of the final character of a word (last digit, or LF when CRLF=1).
  localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1 + 2 * CRLF);
  // Index of the CR character; only reached when CRLF=1.
  localparam logic [3:0] CR_IDX   = 4'(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  state_e       state_q, state_d;
  // Holds the digits not yet presented, left-aligned: the next digit is
  // always the top nibble, so the word shifts left by one nibble per digit.
  logic [W-1:0] word_q,  word_d;
  logic [3:0]   idx_q,   idx_d;
  logic [7:0]   data_q,  data_d;
  logic [3:0]   next_idx_s;

  // Map a nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  assign tx_data = data_q;

  // Next-state, next-character and handshake outputs.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    data_d     = data_q;
    ready      = 1'b0;
    tx_start   = 1'b0;
    done       = 1'b0;
    next_idx_s = idx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          // The first digit is presented straight from din; the register
          // keeps only the digits still to come.
          data_d  = hex_ascii(din[W-1 -: 4]);
          word_d  = din << 3'd4;
          idx_d   = 4'd0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        // A busy transmitter here is finishing a frame we did not start
        // (e.g. one begun before a reset), so hold off until it is free.
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_HI;
        end else begin
          state_d  = S_LOAD;
        end
      end

      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else begin
          state_d = S_WAIT_HI;
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = next_idx_s;
            state_d = S_LOAD;
            if (next_idx_s < CR_IDX) begin
              data_d = hex_ascii(word_q[W-1 -: 4]);
              word_d = word_q << 3'd4;
            end else if (next_idx_s == CR_IDX) begin
              data_d = 8'h0D;
            end else begin
              data_d = 8'h0A;
            end
          end
        end else begin
          state_d = S_WAIT_LO;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, character index, remaining digits and presented byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= 4'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx
// Two instances: an 8-digit word with CR LF (serial transmitter model plus
// line decoder) and a 2-digit word without CR LF (short busy model).
// A behavioural model predicts, from the submitted words, the byte stream,
// the cycle of every start strobe, ready and the done pulse; one compare
// process checks them every cycle. Directed tests pin the model with
// hand-written byte lists.
module tb_uart_hex_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din8;
  logic        valid8, ready8, tx_start8, done8, busy8;
  logic [7:0]  tx_data8;
  logic [7:0]  din2;
  logic        valid2, ready2, tx_start2, done2, busy2;
  logic [7:0]  tx_data2;

  uart_hex_tx #(.NIBBLES(8), .CRLF(1)) u_dut8 (
    .clk(clk), .rst(rst), .din(din8), .valid(valid8), .ready(ready8),
    .tx_data(tx_data8), .tx_start(tx_start8), .tx_busy(busy8), .done(done8)
  );

  uart_hex_tx #(.NIBBLES(2), .CRLF(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .valid(valid2), .ready(ready2),
    .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(busy2), .done(done2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transmitter for the 8-digit instance ----------------
  int         bc = 208;          // clocks per bit
  int         cnt8 = 0;          // cycles of frame remaining
  logic [9:0] frame8 = 10'h3FF;
  logic       force_busy = 1'b0;
  logic       line8;

  always @(posedge clk) begin
    if (tx_start8 && cnt8 == 0) begin
      cnt8   <= 10 * bc;
      frame8 <= {1'b1, tx_data8, 1'b0};
    end else if (cnt8 != 0) begin
      cnt8 <= cnt8 - 1;
    end
  end
  assign busy8 = (cnt8 != 0) || force_busy;
  assign line8 = (cnt8 == 0) ? 1'b1 : frame8[4'((10 * bc - cnt8) / bc)];

  // Serial decoder: samples mid-bit after a falling start edge.
  logic       rx_act = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!rx_act) begin
      if (!line8) begin
        rx_act <= 1'b1;
        rx_t   <= 1;
      end
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t == bc / 2 + 9 * bc) begin
        rx_q.push_back(rx_sh);
        rx_act <= 1'b0;
      end else if (rx_t >= bc / 2 + bc && (rx_t - bc / 2) % bc == 0) begin
        rx_sh <= {line8, rx_sh[7:1]};
      end
    end
  end

  // ---------------- transmitter for the 2-digit instance ----------------
  int cnt2 = 0;
  always @(posedge clk) begin
    if (tx_start2 && cnt2 == 0) cnt2 <= 12;
    else if (cnt2 != 0) cnt2 <= cnt2 - 1;
  end
  assign busy2 = (cnt2 != 0);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model state per instance (0: 8-digit, 1: 2-digit).
  bit         m_inflight[2];   // a word has been accepted and not finished
  bit         m_due[2];        // a byte is waiting for the transmitter
  bit         m_ack[2];        // started, transmitter not yet seen busy
  bit         m_end[2];        // transmitter seen busy, waiting for idle
  logic [7:0] mf[2][0:15];     // expected bytes of the current word
  int         mh[2], mt[2];
  logic [7:0] log_b[2][0:63];  // bytes seen at each start strobe
  int         log_c[2][0:63];  // cycle of each start strobe
  int         log_n[2];
  int         done_cnt[2];

  task automatic model_cycle(input int d, input logic rdy, input logic st, input logic dn,
                             input logic bsy, input logic vld, input logic [7:0] td,
                             input logic [31:0] w, input int nib, input bit crlf);
    bit    exp_ready, exp_start, fin, exp_done;
    string tag;
    tag       = (d == 0) ? "w8" : "w2";
    exp_ready = !m_inflight[d];
    exp_start = m_due[d] && !bsy;
    fin       = m_end[d] && !bsy;
    exp_done  = fin && (mh[d] == mt[d]);
    check({tag, "_ready"}, rdy, exp_ready);
    check({tag, "_tx_start"}, st, exp_start);
    check({tag, "_done"}, dn, exp_done);
    if (st && exp_start) check({tag, "_tx_data"}, td, mf[d][mh[d]]);
    if (st && log_n[d] < 64) begin
      log_b[d][log_n[d]] = td;
      log_c[d][log_n[d]] = cyc;
      log_n[d]++;
    end
    if (dn) done_cnt[d]++;
    if (exp_start) begin
      m_due[d] = 1'b0;
      m_ack[d] = 1'b1;
      mh[d]++;
    end else if (m_ack[d] && bsy) begin
      m_ack[d] = 1'b0;
      m_end[d] = 1'b1;
    end else if (fin) begin
      m_end[d] = 1'b0;
      if (mh[d] == mt[d]) m_inflight[d] = 1'b0;
      else m_due[d] = 1'b1;
    end
    if (vld && exp_ready) begin
      for (int k = 0; k < nib; k++) begin
        int n;
        n = int'((w >> (4 * (nib - 1 - k))) & 32'hF);
        mf[d][k] = (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
      end
      if (crlf) begin
        mf[d][nib]     = 8'h0D;
        mf[d][nib + 1] = 8'h0A;
      end
      mh[d]         = 0;
      mt[d]         = nib + (crlf ? 2 : 0);
      m_inflight[d] = 1'b1;
      m_due[d]      = 1'b1;
    end
  endtask

  // Compare process: every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_ready8", ready8, 1'b1);
        check("rst_start8", tx_start8, 1'b0);
        check("rst_data8", tx_data8, 8'h00);
        check("rst_done8", done8, 1'b0);
        check("rst_data2", tx_data2, 8'h00);
        for (int d = 0; d < 2; d++) begin
          m_inflight[d] = 1'b0; m_due[d] = 1'b0; m_ack[d] = 1'b0; m_end[d] = 1'b0;
          mh[d] = 0; mt[d] = 0;
        end
      end else begin
        model_cycle(0, ready8, tx_start8, done8, busy8, valid8, tx_data8, din8, 8, 1'b1);
        model_cycle(1, ready2, tx_start2, done2, busy2, valid2, tx_data2, {24'h0, din2}, 2, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] exp_t1 [0:9]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] exp_t2 [0:3]  = '{8'h30, 8'h46, 8'h41, 8'h39};
  logic [7:0] exp_t3 [0:9]  = '{8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45, 8'h30, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] exp_t4 [0:9]  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] exp_t5 [0:9]  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
  logic [7:0] exp_t6 [0:19] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0D, 8'h0A,
                                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};

  task automatic send8(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    din8   = w;
    valid8 = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ready8) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid8 = 1'b0;
    check("accept8", ok, 1'b1);
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((d == 0 && done8) || (d == 1 && done2)) begin seen = 1'b1; break; end
    end
    check((d == 0) ? "done8_wait" : "done2_wait", seen, 1'b1);
  endtask

  initial begin
    int wi, d1, base;
    bit acc;
    rst = 1'b0; valid8 = 1'b0; din8 = 32'h0; valid2 = 1'b0; din2 = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", ready8, 1'b1);
    check("reset_tx_start", tx_start8, 1'b0);
    check("reset_tx_data", tx_data8, 8'h00);
    check("reset_done", done8, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("release_ready8", ready8, 1'b1);
    check("release_ready2", ready2, 1'b1);

    // 0x1234ABCF at 208 clk/bit, serial line decoded.
    rx_q.delete(); log_n[0] = 0; done_cnt[0] = 0;
    send8(32'h1234ABCF);
    wait_done(0, 30000);
    repeat (20) @(negedge clk);
    check("t1_starts", log_n[0], 10);
    check("t1_dones", done_cnt[0], 1);
    for (int i = 0; i < 10; i++) check($sformatf("t1_byte%0d", i), log_b[0][i], exp_t1[i]);
    check("t1_rx_count", rx_q.size(), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      check($sformatf("t1_rx%0d", i), rx_q[i], exp_t1[i]);
    bc = 16;

    // 2-digit, no CRLF: 0x0F then 0xA9 with valid held high.
    log_n[1] = 0; done_cnt[1] = 0;
    @(posedge clk); #1;
    din2 = 8'h0F; valid2 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready2) begin acc = 1'b1; break; end
    end
    check("t2_accept_first", acc, 1'b1);
    @(posedge clk); #1 din2 = 8'hA9;
    wait_done(1, 500);
    d1 = cyc;
    wi = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready2) begin wi = i; break; end
    end
    check("t2_ready_after_done", wi, 0);
    @(posedge clk); #1 valid2 = 1'b0;
    wait_done(1, 500);
    check("t2_starts", log_n[1], 4);
    check("t2_dones", done_cnt[1], 2);
    for (int i = 0; i < 4; i++) check($sformatf("t2_byte%0d", i), log_b[1][i], exp_t2[i]);
    check("t2_done_to_start_gap", log_c[1][2] - d1, 2);

    // valid pulsed mid-word is ignored.
    log_n[0] = 0; done_cnt[0] = 0;
    send8(32'hC0FFEE00);
    repeat (100) @(posedge clk);
    #1 din8 = 32'h5; valid8 = 1'b1;
    @(posedge clk); #1 valid8 = 1'b0; din8 = 32'h0;
    wait_done(0, 5000);
    repeat (10) @(negedge clk);
    check("t3_starts", log_n[0], 10);
    check("t3_dones", done_cnt[0], 1);
    for (int i = 0; i < 10; i++) check($sformatf("t3_byte%0d", i), log_b[0][i], exp_t3[i]);

    // Busy held externally for 50 cycles when the word is accepted.
    log_n[0] = 0; done_cnt[0] = 0;
    force_busy = 1'b1;
    send8(32'h00000010);
    base = log_n[0];
    repeat (50) @(negedge clk);
    check("t4_held_no_start", log_n[0] - base, 0);
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    check("t4_start_on_release", tx_start8, 1'b1);
    wait_done(0, 5000);
    for (int i = 0; i < 10; i++) check($sformatf("t4_byte%0d", i), log_b[0][i], exp_t4[i]);

    // Reset during the third byte of 0xDEADBEEF, then 0x00000001.
    log_n[0] = 0;
    send8(32'hDEADBEEF);
    acc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (log_n[0] >= 3) begin acc = 1'b1; break; end
    end
    check("t5_reached_byte3", acc, 1'b1);
    check("t5_byte2", log_b[0][2], 8'h41);
    repeat (40) @(negedge clk);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("t5_async_ready", ready8, 1'b1);
    check("t5_async_tx_start", tx_start8, 1'b0);
    check("t5_async_tx_data", tx_data8, 8'h00);
    check("t5_async_done", done8, 1'b0);
    log_n[0] = 0; done_cnt[0] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_ready_after_release", ready8, 1'b1);
    send8(32'h00000001);
    wait_done(0, 5000);
    check("t5_starts", log_n[0], 10);
    check("t5_dones", done_cnt[0], 1);
    for (int i = 0; i < 10; i++) check($sformatf("t5_byte%0d", i), log_b[0][i], exp_t5[i]);

    // All sixteen nibble values over two words.
    log_n[0] = 0;
    send8(32'h01234567);
    wait_done(0, 5000);
    send8(32'h89ABCDEF);
    wait_done(0, 5000);
    check("t6_starts", log_n[0], 20);
    for (int i = 0; i < 20; i++) check($sformatf("t6_byte%0d", i), log_b[0][i], exp_t6[i]);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
